// File: rtl/tsc_load_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tsc_load_decoder
//  Purpose  : Recovers the 8 key bits carried on the replicated 64-bit TSC
//             load vector. Each lane is majority-voted and unmasked with the
//             aligned lfsr_counter bit. Signed saturating votes accumulate
//             over a window, then the key and confidence are reported.
//  Revision : 1.0 - initial release
// ============================================================================
module tsc_load_decoder #(
  parameter int WINDOW = 16,
  parameter int CONF_W = 5,
  parameter int THRESH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] load,
  input  logic [19:0] counter,
  input  logic        load_valid,
  output logic        busy,
  output logic        done,
  output logic [7:0]  key_out,
  output logic [7:0]  key_conf,
  output logic [7:0]  tie_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  localparam logic [7:0]               C_WINDOW_M1 = 8'(WINDOW - 1);
  localparam logic [CONF_W-1:0]        C_THRESH    = CONF_W'(THRESH);
  localparam logic signed [CONF_W:0]   C_SAT_POS   = $signed((CONF_W+1)'((1 << (CONF_W - 1)) - 1));
  localparam logic signed [CONF_W:0]   C_SAT_NEG   = -C_SAT_POS;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic signed [CONF_W-1:0]  r_acc [8];
  logic signed [CONF_W-1:0]  w_acc_nxt [8];
  logic [7:0]                r_cnt;
  logic [7:0]                r_ties;
  logic [7:0]                w_tie;
  logic [3:0]                w_tie_lanes;
  logic [8:0]                w_ties_sum;
  logic [7:0]                w_ties_nxt;
  logic                      w_accept;
  logic                      w_clear;
  logic                      w_last;

  // Eight-bit population count used for the per-lane majority vote.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int b = 0; b < 8; b++) begin
      n = n + {3'b000, v[b]};
    end
    return n;
  endfunction

  // A start outside REPORT always opens a fresh window and swallows that cycle's sample.
  assign w_clear  = start && (r_state != S_REPORT);
  assign w_accept = (r_state == S_ACCUM) && load_valid && !start;
  assign w_last   = (r_cnt == C_WINDOW_M1);
  assign busy     = (r_state != S_IDLE);

  // Per-lane decode: majority vote, unmask with counter bit, saturating accumulate.
  for (genvar i = 0; i < 8; i++) begin : g_lane
    logic [3:0]               w_pop;
    logic                     w_bit;
    logic signed [CONF_W:0]   w_vote;
    logic signed [CONF_W:0]   w_sum;

    assign w_pop    = popcount8(load[8*i +: 8]);
    assign w_tie[i] = (w_pop == 4'd4);
    assign w_bit    = (w_pop >= 4'd5) ^ counter[i];
    assign w_vote   = w_tie[i] ? '0 : (w_bit ? (CONF_W+1)'(1) : {(CONF_W+1){1'b1}});
    assign w_sum    = {r_acc[i][CONF_W-1], r_acc[i]} + w_vote;

    // Clamp the widened sum to the symmetric range so the accumulator never wraps.
    always_comb begin
      w_acc_nxt[i] = w_sum[CONF_W-1:0];
      if (w_sum > C_SAT_POS) begin
        w_acc_nxt[i] = C_SAT_POS[CONF_W-1:0];
      end else if (w_sum < C_SAT_NEG) begin
        w_acc_nxt[i] = C_SAT_NEG[CONF_W-1:0];
      end
    end
  end

  // Count tied lanes in this sample and add to the window total, saturating at 255.
  always_comb begin
    w_tie_lanes = '0;
    for (int i = 0; i < 8; i++) begin
      w_tie_lanes = w_tie_lanes + {3'b000, w_tie[i]};
    end
    w_ties_sum = {1'b0, r_ties} + {5'b00000, w_tie_lanes};
    w_ties_nxt = w_ties_sum[8] ? 8'hFF : w_ties_sum[7:0];
  end

  // Next-state logic: IDLE -> ACCUM on start, ACCUM -> REPORT on the last sample.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_ACCUM;
      S_ACCUM:  if (w_accept && w_last) w_state_nxt = S_REPORT;
      S_REPORT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State, accumulators and reported results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ties   <= '0;
      done     <= 1'b0;
      key_out  <= '0;
      key_conf <= '0;
      tie_cnt  <= '0;
      for (int i = 0; i < 8; i++) begin
        r_acc[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      done    <= 1'b0;
      if (w_clear) begin
        r_cnt  <= '0;
        r_ties <= '0;
        for (int i = 0; i < 8; i++) begin
          r_acc[i] <= '0;
        end
      end else if (w_accept) begin
        r_cnt  <= r_cnt + 8'd1;
        r_ties <= w_ties_nxt;
        for (int i = 0; i < 8; i++) begin
          r_acc[i] <= w_acc_nxt[i];
        end
      end
      if (r_state == S_REPORT) begin
        done    <= 1'b1;
        tie_cnt <= r_ties;
        for (int i = 0; i < 8; i++) begin
          key_out[i]  <= !r_acc[i][CONF_W-1] && (r_acc[i] != '0);
          key_conf[i] <= ((r_acc[i][CONF_W-1] ? -r_acc[i] : r_acc[i]) >= C_THRESH);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tsc_load_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tsc_load_decoder
//  Purpose  : Scoreboard bench for tsc_load_decoder with a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tsc_load_decoder;

  localparam int WINDOW = 16;
  localparam int CONF_W = 5;
  localparam int THRESH = 4;
  localparam int LIM    = (1 << (CONF_W - 1)) - 1;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] load;
  logic [19:0] counter;
  logic        load_valid;
  logic        busy;
  logic        done;
  logic [7:0]  key_out;
  logic [7:0]  key_conf;
  logic [7:0]  tie_cnt;

  tsc_load_decoder #(.WINDOW(WINDOW), .CONF_W(CONF_W), .THRESH(THRESH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .load       (load),
    .counter    (counter),
    .load_valid (load_valid),
    .busy       (busy),
    .done       (done),
    .key_out    (key_out),
    .key_conf   (key_conf),
    .tie_cnt    (tie_cnt)
  );

  typedef struct {
    int         cyc;
    logic [7:0] key;
    logic [7:0] conf;
    logic [7:0] ties;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit check_en = 0;

  // Reference model state (plain integers)
  bit m_active = 0;
  bit m_report = 0;
  int m_acc [8];
  int m_cnt  = 0;
  int m_ties = 0;

  // Expected registered-state visibility, staged one cycle
  bit nxt_busy = 0, cur_busy = 0;
  bit nxt_rst  = 0, cur_rst  = 0;
  logic [7:0] hold_key = 0, hold_conf = 0, hold_ties = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard when done is seen and checks held outputs and busy.
  always @(negedge clk) begin
    if (check_en) begin
      if (cur_rst) begin
        hold_key = 0; hold_conf = 0; hold_ties = 0;
      end
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("key_out", {24'd0, key_out}, {24'd0, e.key});
          chk("key_conf", {24'd0, key_conf}, {24'd0, e.conf});
          chk("tie_cnt", {24'd0, tie_cnt}, {24'd0, e.ties});
          hold_key = e.key; hold_conf = e.conf; hold_ties = e.ties;
        end
      end else begin
        chk("done_low", {31'd0, done}, 0);
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          chk("done_missing", 0, 1);
          void'(sb.pop_front());
        end
        chk("hold_key", {24'd0, key_out}, {24'd0, hold_key});
        chk("hold_conf", {24'd0, key_conf}, {24'd0, hold_conf});
        chk("hold_ties", {24'd0, tie_cnt}, {24'd0, hold_ties});
      end
      chk("busy", {31'd0, busy}, {31'd0, cur_busy});
    end
  end

  // Applies one cycle of stimulus and advances the behavioural model.
  task automatic drive_cycle(input bit r, input bit st, input bit lv,
                             input logic [63:0] ld, input logic [19:0] cn);
    cur_busy = nxt_busy;
    cur_rst  = nxt_rst;
    rst = r; start = st; load_valid = lv; load = ld; counter = cn;
    if (r) begin
      m_active = 0; m_report = 0;
    end else if (m_report) begin
      m_report = 0;
    end else if (st) begin
      m_active = 1; m_cnt = 0; m_ties = 0;
      for (int i = 0; i < 8; i++) m_acc[i] = 0;
    end else if (m_active && lv) begin
      for (int i = 0; i < 8; i++) begin
        int p;
        logic [7:0] lane;
        lane = ld[8*i +: 8];
        p = $countones(lane);
        if (p == 4) begin
          if (m_ties < 255) m_ties++;
        end else begin
          int v;
          v = ((p >= 5) ^ cn[i]) ? 1 : -1;
          m_acc[i] = m_acc[i] + v;
          if (m_acc[i] > LIM) m_acc[i] = LIM;
          if (m_acc[i] < -LIM) m_acc[i] = -LIM;
        end
      end
      m_cnt++;
      if (m_cnt == WINDOW) begin
        exp_t e;
        e.cyc = cyc + 2;
        for (int i = 0; i < 8; i++) begin
          e.key[i]  = (m_acc[i] > 0);
          e.conf[i] = (m_acc[i] >= THRESH) || (-m_acc[i] >= THRESH);
        end
        e.ties = 8'(m_ties);
        sb.push_back(e);
        m_active = 0; m_report = 1;
      end
    end
    nxt_rst  = r;
    nxt_busy = m_active || m_report;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive_cycle(0, 0, 1'($urandom), rnd64(), 20'($urandom));
  endtask

  // Start (with a sample that must be ignored) followed by n contiguous samples.
  task automatic run_window(input logic [63:0] ld, input logic [19:0] cn, input int n);
    drive_cycle(0, 1, 1, rnd64(), 20'($urandom));
    for (int k = 0; k < n; k++) drive_cycle(0, 0, 1, ld, cn);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_acc[i] = 0;
    rst = 1; start = 0; load_valid = 0; load = '0; counter = '0;
    drive_cycle(1, 0, 0, '0, '0);
    check_en = 1;
    drive_cycle(1, 1, 1, rnd64(), '0);
    idle(3);

    // Clean decode and counter unmasking
    run_window(64'hFF00FF00FF00FF00, 20'h00000, 16);
    idle(4);
    run_window(64'hFF00FF00FF00FF00, 20'h000FF, 16);
    idle(4);
    // Tie lane 0, upper counter bits must not matter
    run_window(64'h00000000_0000000F, 20'hABC00, 16);
    idle(4);

    // Threshold edge on lane 3: 10/6 then 9/7
    for (int split = 10; split >= 9; split--) begin
      drive_cycle(0, 1, 0, '0, '0);
      for (int k = 0; k < 16; k++)
        drive_cycle(0, 0, 1, (k < split) ? 64'h00000000_FF000000 : 64'h0, '0);
      idle(3);
    end

    // Restart after 7 samples, then 16 samples with gaps every other cycle
    run_window(64'hFFFFFFFFFFFFFFFF, '0, 7);
    drive_cycle(0, 1, 1, 64'hFFFFFFFFFFFFFFFF, '0);
    for (int k = 0; k < 32; k++)
      drive_cycle(0, 0, (k % 2) == 0, (k % 2) == 0 ? 64'h00FF00FF00FF00FF : 64'hFFFFFFFFFFFFFFFF, '0);
    idle(3);

    // Reset mid-window, then a fresh decode
    run_window(64'h0F0F0F0F0F0F0F0F, 20'h0005A, 8);
    drive_cycle(1, 0, 1, rnd64(), '0);
    idle(3);
    run_window(64'hF0F8FC7F3F1E0701, 20'h000C3, 16);
    idle(4);

    // Random traffic: sparse starts, random valid, lane patterns mixing strong/weak/tie
    for (int k = 0; k < 900; k++) begin
      logic [63:0] ld;
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(0, 3))
          0: ld[8*i +: 8] = 8'hFF;
          1: ld[8*i +: 8] = 8'h00;
          2: ld[8*i +: 8] = 8'h3C;
          default: ld[8*i +: 8] = 8'($urandom);
        endcase
      end
      drive_cycle(0, $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, ld, 20'($urandom));
    end
    idle(WINDOW + 4);
    drive_cycle(0, 0, 0, '0, '0);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d results outstanding, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tsc_load_decoder.md
Name: tsc_load_decoder

Overview:
- Recovers the 8 key bits carried on the 64-bit side-channel load vector driven by the TSC leakage block. That block drives each key bit, XORed with lfsr_counter bit i, onto 8 replicated load lines: lane i = load[8i+7:8i].
- Sits on the evaluation/monitor side. It takes sampled load vectors plus the matching lfsr_counter value, majority-votes each lane, and accumulates votes over a window. It reports the recovered key byte and a per-bit confidence mask.

Parameters:
- WINDOW, 16: number of accepted samples per decision (range 1..255).
- CONF_W, 5: width of each signed per-bit vote accumulator.
- THRESH, 4: minimum |accumulator| for a bit to be marked confident (must be ≤ 2^(CONF_W-1)-1).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; begins a new decode window
- load  in  64  sampled load vector
- counter  in  20  lfsr_counter value aligned to this load sample; only [7:0] used
- load_valid  in  1  load/counter valid this cycle
- busy  out  1  high in ACCUM and REPORT
- done  out  1  one-cycle pulse; results valid
- key_out  out  8  recovered key bits [7:0]
- key_conf  out  8  per-bit confidence mask
- tie_cnt  out  8  total tied lanes seen in the last window, saturating at 255

Behaviour:
- Reset: only one clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk. On reset:
  - state = IDLE;
  - busy, done, key_out, key_conf and tie_cnt = 0;
  - accumulators and sample count = 0.
  - rst has priority over start and load_valid.
- States:
  - IDLE: start → ACCUM. Clears accumulators, sample count and the internal tie counter. load_valid in the start cycle is ignored.
  - ACCUM: a sample is accepted when load_valid=1 and start=0.
    - start=1 in ACCUM restarts the window: clear as above, stay in ACCUM, and ignore that cycle's sample.
    - When the accepted sample is the WINDOW-th, go to REPORT.
  - REPORT: exactly one cycle. At the end of that cycle:
    - key_out[i] <= (acc[i] > 0);
    - key_conf[i] <= (|acc[i]| ≥ THRESH);
    - tie_cnt <= internal tie counter;
    - done <= 1 for one cycle;
    - state → IDLE.
    - start and load_valid are ignored in REPORT.
- Per-lane decode, combinational on the accepted sample:
  - pop = popcount(load[8i+7:8i]).
  - pop ≥ 5 → lane bit 1. pop ≤ 3 → lane bit 0. pop == 4 → tie.
  - Key estimate = lane bit XOR counter[i].
  - Vote: +1 if the estimate is 1, −1 if it is 0, 0 on a tie.
  - Each tie increments the internal tie counter, saturating at 255.
- Accumulator arithmetic:
  - Two's complement, CONF_W bits, updated at the edge ending the accepting cycle.
  - Saturates at ±(2^(CONF_W-1)−1), i.e. ±15 at default; it never wraps.
  - acc == 0 → key_out bit 0, key_conf bit 0.
- Latency: final sample accepted in cycle N → REPORT in cycle N+1 → done, key_out, key_conf and tie_cnt visible in cycle N+2.
- Output holding: key_out, key_conf and tie_cnt hold until the next REPORT or rst. They do not change on start.
- Gaps: load_valid gaps in ACCUM stall accumulation with no timeout. counter[19:8] is ignored.

Test Plan:
- Clean decode: rst, start, then 16 samples of load=64'hFF00FF00FF00FF00 with counter=0.
  → done 2 cycles after the 16th sample; key_out=8'hAA; key_conf=8'hFF; tie_cnt=0; all accumulators saturated at ±15.
- Counter unmasking: same load with counter=20'h000FF.
  → key_out=8'h55, key_conf=8'hFF.
- Tie lanes: lane0=8'h0F every sample, other lanes 8'h00, counter=0.
  → key_out=8'h00; key_conf=8'hFE; tie_cnt=16.
- Threshold edge: lane3 votes 1 for 10 samples and 0 for 6 (acc=+4).
  → key_out[3]=1, key_conf[3]=1.
  Repeat with 9/7 (acc=+2).
  → key_out[3]=1, key_conf[3]=0.
- Restart and stalls:
  - start after 7 samples, then 16 more samples with load_valid toggling every other cycle.
    → result reflects only the 16 post-restart samples; busy stays high throughout.
  - A sample presented in the same cycle as start is not counted.
- Reset mid-window: rst asserted after 8 samples.
  → next cycle busy=0, key_out=0, key_conf=0, tie_cnt=0, no done pulse.
  → a subsequent start plus 16 samples decodes correctly.
